// File: rtl/instr_mem_interface_if.sv
// Fetch/programmer bus for instr_mem_interface: request fields from the core side,
// returned word, address and status from the memory side.
interface instr_mem_interface_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    read;
  logic                    write;
  logic [ADDRESS_BITS-1:0] write_address;
  logic [ADDRESS_BITS-1:0] read_address;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [ADDRESS_BITS-1:0] out_addr;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    valid;
  logic                    ready;

  modport master (
    output read, write, write_address, read_address, in_data,
    input  out_addr, out_data, valid, ready
  );

  modport slave (
    input  read, write, write_address, read_address, in_data,
    output out_addr, out_data, valid, ready
  );
endinterface

// File: rtl/instr_mem_interface.sv
// Word-addressed instruction store: same-cycle fetch port, clocked programmer write port.
// Define MEM_INTERFACE_WR_FWD_EN to forward same-index write data onto the fetch port.
module instr_mem_interface #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_BITS   = 6,
  parameter int OFFSET_BITS  = 3,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  report,
  instr_mem_interface_if.slave  bus
);
  localparam int IDX_W = INDEX_BITS + OFFSET_BITS;
  localparam int DEPTH = 1 << IDX_W;

  typedef struct packed {
    logic                    vld;
    logic [ADDRESS_BITS-1:0] addr;
    logic [DATA_WIDTH-1:0]   data;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic [31:0]           cycles;
  rsp_t                  rsp;

  // Addresses alias modulo the depth; upper write bits carry no information.
  assign rd_idx = bus.read_address[IDX_W-1:0];
  assign wr_idx = bus.write_address[IDX_W-1:0];

  logic unused_wr_hi;
  assign unused_wr_hi = ^bus.write_address[ADDRESS_BITS-1:IDX_W];

  // Programming happens with the core held in reset, so writes ignore reset.
  always_ff @(posedge clock) begin
    if (bus.write) mem[wr_idx] <= bus.in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) cycles <= '0;
    else       cycles <= cycles + 32'd1;
  end

  always_comb begin
    rsp = '0;
    if (bus.read && !reset) begin
      rsp.vld  = 1'b1;
      rsp.addr = bus.read_address;
      rsp.data = mem[rd_idx];
`ifdef MEM_INTERFACE_WR_FWD_EN
      if (bus.write && (wr_idx == rd_idx)) rsp.data = bus.in_data;
`endif
    end
  end

  assign bus.valid    = rsp.vld;
  assign bus.out_addr = rsp.addr;
  assign bus.out_data = rsp.data;
  assign bus.ready    = !reset && !bus.write;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report)
      $display("core %0d cyc %0d rd %b wr %b ra %h wa %h wd %h oa %h od %h vld %b rdy %b",
               CORE, cycles, bus.read, bus.write, bus.read_address, bus.write_address,
               bus.in_data, bus.out_addr, bus.out_data, bus.valid, bus.ready);
  end
`endif
endmodule

// File: tb/tb_instr_mem_interface.sv
// Directed plan cases plus randomized traffic against an array-based memory model.
module tb_instr_mem_interface;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int IW = 9;

`ifdef MEM_INTERFACE_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic report;

  instr_mem_interface_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) bus ();

  instr_mem_interface #(.CORE(0), .DATA_WIDTH(DW), .INDEX_BITS(6), .OFFSET_BITS(3),
                        .ADDRESS_BITS(AW)) dut (
    .clock (clock),
    .reset (reset),
    .report(report),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] m_mem   [1 << IW];
  bit            m_known [1 << IW];
  logic [31:0]   m_cyc;
  bit            m_cyc_known = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Apply inputs for one cycle and check the combinational response against the model.
  task automatic drive(input logic rst, input logic rd, input logic wr,
                       input logic [AW-1:0] ra, input logic [AW-1:0] wa, input logic [DW-1:0] d);
    logic          ev, erdy;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            ri, wi;
    reset = rst; bus.read = rd; bus.write = wr;
    bus.read_address = ra; bus.write_address = wa; bus.in_data = d;
    #2;
    ri   = int'(ra) % (1 << IW);
    wi   = int'(wa) % (1 << IW);
    ev   = rd && !rst;
    erdy = !rst && !wr;
    ea   = ev ? ra : '0;
    if (!ev)                        ed = '0;
    else if (FWD && wr && ri == wi) ed = d;
    else                            ed = m_mem[ri];
    chk("valid", {63'd0, bus.valid}, {63'd0, ev});
    chk("ready", {63'd0, bus.ready}, {63'd0, erdy});
    chk("out_addr", {44'd0, bus.out_addr}, {44'd0, ea});
    if (!ev || m_known[ri] || (FWD && wr && ri == wi))
      chk("out_data", {32'd0, bus.out_data}, {32'd0, ed});
    if (m_cyc_known) chk("cycles", {32'd0, dut.cycles}, {32'd0, m_cyc});
  endtask

  task automatic tick();
    @(posedge clock);
    if (bus.write) begin
      m_mem[int'(bus.write_address) % (1 << IW)]   = bus.in_data;
      m_known[int'(bus.write_address) % (1 << IW)] = 1'b1;
    end
    if (reset) begin
      m_cyc = 0; m_cyc_known = 1'b1;
    end else if (m_cyc_known) m_cyc = m_cyc + 1;
    #1;
  endtask

  initial begin
    logic [AW-1:0] ra, wa;
    logic          rst, rd, wr;
    report = 1'b0;
    for (int i = 0; i < (1 << IW); i++) m_known[i] = 1'b0;

    // Program during reset; outputs stay quiet even with read asserted.
    drive(1, 1, 1, 20'h4, 20'h4, 32'h00500093);
    chk("rst_valid", {63'd0, bus.valid}, 64'd0);
    chk("rst_ready", {63'd0, bus.ready}, 64'd0);
    chk("rst_data", {32'd0, bus.out_data}, 64'd0);
    chk("rst_addr", {44'd0, bus.out_addr}, 64'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, '0, AW'((i * 31) + 9 * 512), $urandom);
      tick();
    end
    drive(1, 0, 1, '0, 20'h0, 32'hA0A0A0A0); tick();
    drive(1, 0, 1, '0, 20'h1, 32'hA1A1A1A1); tick();
    drive(1, 0, 1, '0, 20'h2, 32'hA2A2A2A2); tick();
    drive(1, 0, 1, '0, 20'h10, 32'h11111111); tick();

    // First fetch after release.
    drive(0, 1, 0, 20'h4, '0, '0);
    chk("fetch_data", {32'd0, bus.out_data}, 64'h00500093);
    chk("fetch_addr", {44'd0, bus.out_addr}, 64'h4);
    chk("fetch_valid", {63'd0, bus.valid}, 64'd1);
    chk("fetch_ready", {63'd0, bus.ready}, 64'd1);
    chk("cyc_zero", {32'd0, dut.cycles}, 64'd0);
    tick();

    drive(0, 0, 0, 20'h55, '0, '0);
    chk("idle_valid", {63'd0, bus.valid}, 64'd0);
    chk("idle_ready", {63'd0, bus.ready}, 64'd1);
    chk("idle_data", {32'd0, bus.out_data}, 64'd0);
    tick();

    drive(0, 0, 1, '0, 20'h7, 32'hDEADBEEF); tick();
    drive(0, 1, 0, 20'h207, '0, '0);
    chk("alias_data", {32'd0, bus.out_data}, 64'hDEADBEEF);
    chk("alias_addr", {44'd0, bus.out_addr}, 64'h207);
    tick();

    // Same-index read and write.
    drive(0, 1, 1, 20'h10, 20'h10, 32'h22222222);
    chk("rw_data", {32'd0, bus.out_data}, FWD ? 64'h22222222 : 64'h11111111);
    chk("rw_ready", {63'd0, bus.ready}, 64'd0);
    tick();
    drive(0, 1, 0, 20'h10, '0, '0);
    chk("rw_next", {32'd0, bus.out_data}, 64'h22222222);
    tick();

    drive(0, 1, 0, 20'h0, '0, '0);
    chk("b2b_0", {32'd0, bus.out_data}, 64'hA0A0A0A0); tick();
    drive(0, 1, 0, 20'h1, '0, '0);
    chk("b2b_1", {32'd0, bus.out_data}, 64'hA1A1A1A1);
    chk("b2b_1a", {44'd0, bus.out_addr}, 64'h1); tick();
    drive(0, 1, 0, 20'h2, '0, '0);
    chk("b2b_2", {32'd0, bus.out_data}, 64'hA2A2A2A2); tick();

    // Reset mid-operation: outputs drop, the write still lands.
    drive(1, 1, 1, 20'h3, 20'h3, 32'hC0FFEE00);
    chk("midrst_valid", {63'd0, bus.valid}, 64'd0);
    tick();
    drive(0, 1, 0, 20'h3, '0, '0);
    chk("midrst_data", {32'd0, bus.out_data}, 64'hC0FFEE00);
    tick();

    report = 1'b1;
    drive(0, 1, 0, 20'h2, '0, '0); tick();
    report = 1'b0;

    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 19) == 0);
      rd  = $urandom_range(0, 3) != 0;
      wr  = $urandom_range(0, 2) == 0;
      ra  = {11'($urandom), 9'(($urandom_range(0, 15) * 31) % 512)};
      wa  = {11'($urandom), 9'(($urandom_range(0, 15) * 31) % 512)};
      if ($urandom_range(0, 4) == 0) wa[8:0] = ra[8:0];
      drive(rst, rd, wr, ra, wa, $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
